// File: rtl/line_cmd_dispatch_if.sv
// Command-FIFO and line-engine signal bundle for line_cmd_dispatch.
//   master : dispatcher side (pops the FIFO, drives the line engine)
//   slave  : FIFO + line-engine side
// Signals:
//   cmd_dout[31:0]     FIFO head word, valid when !cmd_empty
//   cmd_empty          FIFO empty
//   cmd_rd_en          pop FIFO head this cycle
//   LE_ready           line engine in IDLE/SET_UP
//   LE_color[31:0]     {8'b0, rgb}
//   LE_point[19:0]     {x[19:10], y[9:0]}
//   LE_color_valid / LE_point0_valid / LE_point1_valid / LE_trigger  one-cycle pulses
//   LE_frame_base[31:0] frame base presented with every trigger
interface line_cmd_dispatch_if;
    logic [31:0] cmd_dout;
    logic        cmd_empty;
    logic        cmd_rd_en;
    logic        LE_ready;
    logic [31:0] LE_color;
    logic [19:0] LE_point;
    logic        LE_color_valid;
    logic        LE_point0_valid;
    logic        LE_point1_valid;
    logic        LE_trigger;
    logic [31:0] LE_frame_base;

    modport master (
        input  cmd_dout, cmd_empty, LE_ready,
        output cmd_rd_en, LE_color, LE_point, LE_color_valid,
               LE_point0_valid, LE_point1_valid, LE_trigger, LE_frame_base
    );

    modport slave (
        output cmd_dout, cmd_empty, LE_ready,
        input  cmd_rd_en, LE_color, LE_point, LE_color_valid,
               LE_point0_valid, LE_point1_valid, LE_trigger, LE_frame_base
    );
endinterface

// File: rtl/line_cmd_dispatch.sv
// line_cmd_dispatch: pops 32-bit graphics commands (NOP, LINE, SET_FRAME,
// POLYLINE) from a first-word-fall-through FIFO and replays every segment to
// the line engine as colour, point0, point1, trigger. Owns the frame base.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           line_cmd_dispatch_if.master (FIFO + line-engine signals)
//   busy          FSM not in IDLE
//   err_illegal   sticky unknown-opcode flag, cleared only by rst
//   lines_drawn   wrapping count of triggers issued
module line_cmd_dispatch #(
    parameter int unsigned  CNT_W    = 8,
    parameter int unsigned  STAT_W   = 16,
    parameter logic [31:0]  FB_RESET = 32'h1000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    line_cmd_dispatch_if.master    bus,
    output logic                   busy,
    output logic                   err_illegal,
    output logic [STAT_W-1:0]      lines_drawn
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_FB,
        S_FETCH_CNT,
        S_FETCH_P0,
        S_FETCH_P1,
        S_WAIT_LE,
        S_SEND_COL,
        S_SEND_P0,
        S_SEND_P1,
        S_TRIG,
        S_DRAIN
    } state_t;

    state_t             state;
    logic [23:0]        colour;
    logic               poly;
    logic [CNT_W-1:0]   cnt;
    logic [19:0]        p0;
    logic [19:0]        p1;
    logic [31:0]        color_q;
    logic [19:0]        point_q;
    logic [31:0]        frame_base;
    logic               fetch;

    // IDLE pops the header; the FETCH states pop operands.
    assign fetch = (state == S_IDLE)      || (state == S_FETCH_FB) ||
                   (state == S_FETCH_CNT) || (state == S_FETCH_P0) ||
                   (state == S_FETCH_P1);

    assign bus.cmd_rd_en       = fetch && !bus.cmd_empty;
    assign bus.LE_color_valid  = (state == S_SEND_COL);
    assign bus.LE_point0_valid = (state == S_SEND_P0);
    assign bus.LE_point1_valid = (state == S_SEND_P1);
    assign bus.LE_trigger      = (state == S_TRIG);
    assign bus.LE_color        = color_q;
    assign bus.LE_point        = point_q;
    assign bus.LE_frame_base   = frame_base;
    assign busy                = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            colour      <= '0;
            poly        <= 1'b0;
            cnt         <= '0;
            p0          <= '0;
            p1          <= '0;
            color_q     <= '0;
            point_q     <= '0;
            frame_base  <= FB_RESET;
            err_illegal <= 1'b0;
            lines_drawn <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.cmd_empty) begin
                        case (bus.cmd_dout[31:24])
                            8'h00: ;
                            8'h01: begin
                                colour <= bus.cmd_dout[23:0];
                                poly   <= 1'b0;
                                state  <= S_FETCH_P0;
                            end
                            8'h02: state <= S_FETCH_FB;
                            8'h03: begin
                                colour <= bus.cmd_dout[23:0];
                                poly   <= 1'b1;
                                state  <= S_FETCH_CNT;
                            end
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end
                S_FETCH_FB: begin
                    if (!bus.cmd_empty) begin
                        frame_base <= bus.cmd_dout;
                        state      <= S_IDLE;
                    end
                end
                S_FETCH_CNT: begin
                    if (!bus.cmd_empty) begin
                        cnt   <= bus.cmd_dout[CNT_W-1:0];
                        state <= (bus.cmd_dout[CNT_W-1:0] == '0) ? S_IDLE : S_FETCH_P0;
                    end
                end
                S_FETCH_P0: begin
                    if (!bus.cmd_empty) begin
                        p0    <= bus.cmd_dout[19:0];
                        state <= S_FETCH_P1;
                    end
                end
                S_FETCH_P1: begin
                    if (!bus.cmd_empty) begin
                        p1    <= bus.cmd_dout[19:0];
                        state <= S_WAIT_LE;
                    end
                end
                S_WAIT_LE: begin
                    // Load the colour register on the way in so it is valid
                    // in the same cycle as the SEND_COL pulse.
                    if (bus.LE_ready) begin
                        color_q <= {8'h00, colour};
                        state   <= S_SEND_COL;
                    end
                end
                S_SEND_COL: begin
                    point_q <= p0;
                    state   <= S_SEND_P0;
                end
                S_SEND_P0: begin
                    point_q <= p1;
                    state   <= S_SEND_P1;
                end
                S_SEND_P1: state <= S_TRIG;
                S_TRIG: begin
                    lines_drawn <= lines_drawn + 1'b1;
                    state       <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (bus.LE_ready) begin
                        if (poly && (cnt > CNT_W'(1))) begin
                            // Polyline: end point becomes next start point.
                            p0    <= p1;
                            cnt   <= cnt - 1'b1;
                            state <= S_FETCH_P1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
